// File: rtl/band_envelope_pkg.sv
// band_envelope_pkg: shared types and helpers for the per-band envelope follower.
// Holds the sequencing FSM state type, the saturating rectifier and the
// pseudo-log level encoder used when BAND_ENVELOPE_LOG_EN is defined.
package band_envelope_pkg;

  // Sequencer states: wait for strobe, update low band, update high band.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  // Width of the scratch arithmetic used by the helpers below.
  localparam int CALC_W = 32;

  // |x| for a w-bit signed sample, returned as an unsigned value of w-1 bits
  // (zero-extended to CALC_W). The most negative code has no positive twin in
  // w-1 bits, so it clamps to the largest representable magnitude.
  function automatic logic [CALC_W-1:0] abs_sat(input logic signed [CALC_W-1:0] x,
                                                input int w);
    logic [CALC_W-1:0]        max_mag;
    logic signed [CALC_W-1:0] neg;
    max_mag = (CALC_W'(1) << (w - 1)) - CALC_W'(1);
    neg     = -x;
    if (x >= 0) begin
      abs_sat = CALC_W'(x);
    end else if (CALC_W'(neg) > max_mag) begin
      abs_sat = max_mag;
    end else begin
      abs_sat = CALC_W'(neg);
    end
  endfunction

  // Pseudo-log level {e, m}: e = MSB index + 1 (0 for zero input),
  // m = the four bits right below the MSB, zero-filled when the value is short.
  function automatic logic [7:0] log_level(input logic [CALC_W-1:0] v);
    logic [4:0]        msb;
    logic [CALC_W+3:0] shifted;
    msb = '0;
    for (int i = 0; i < CALC_W; i++) begin
      if (v[i]) msb = 5'(i);
    end
    // Append four zero bits, then align the MSB to bit 4 so bits [3:0] are
    // the mantissa regardless of how many bits sit below the MSB.
    shifted = {v, 4'b0000} >> msb;
    if (v == '0) begin
      log_level = 8'h00;
    end else begin
      log_level = {4'(msb + 5'd1), shifted[3:0]};
    end
  endfunction

endpackage

// File: rtl/band_envelope_env_tracker.sv
// env_tracker: one band's rectified peak-hold / exponential-decay envelope.
// On each update strobe: attack to a larger magnitude, else count down hold, else decay.
// env_d exposes the post-update value so the caller can register a level in the same cycle.
module env_tracker #(
  parameter int ENV_W        = 15,
  parameter int HOLD_SAMPLES = 2400,
  parameter int DECAY_SHIFT  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic [ENV_W-1:0] mag,
  output logic [ENV_W-1:0] env_q,
  output logic [ENV_W-1:0] env_d
);

  localparam int HOLD_W = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [ENV_W-1:0]  step;

  // Attack / hold / decay decision for the next envelope and hold count.
  always_comb begin
    env_d  = env_q;
    hold_d = hold_q;
    // Decay step is a fixed fraction of env, but at least 1 while env is
    // non-zero so small envelopes still reach zero; never exceeds env.
    step = env_q >> DECAY_SHIFT;
    if (step == '0 && env_q != '0) begin
      step = ENV_W'(1);
    end
    if (update) begin
      if (mag > env_q) begin
        env_d  = mag;
        hold_d = HOLD_W'(HOLD_SAMPLES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        env_d = env_q - step;
      end
    end
  end

  // Envelope and hold registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      env_q  <= '0;
      hold_q <= '0;
    end else begin
      env_q  <= env_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/band_envelope.sv
// band_envelope: low/high band envelope follower behind the FIR stage; emits one level per band.
// Latency: strobe in cycle 0 -> level_valid pulse and new levels in cycle 3; strobes every >=3 cycles.
// Strobes arriving while busy are dropped and latch the sticky overrun flag. Define
// BAND_ENVELOPE_LOG_EN for pseudo-log levels (LEVEL_WIDTH must then be 8), else linear.
module band_envelope
  import band_envelope_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LEVEL_WIDTH  = 8,
  parameter int DECAY_SHIFT  = 6,
  parameter int HOLD_SAMPLES = 2400
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] low_in,
  input  logic signed [DATA_WIDTH-1:0] high_in,
  output logic [LEVEL_WIDTH-1:0]       low_level,
  output logic [LEVEL_WIDTH-1:0]       high_level,
  output logic                         level_valid,
  output logic                         overrun
);

  localparam int ENV_W = DATA_WIDTH - 1;

`ifdef BAND_ENVELOPE_LOG_EN
  // The log encoding is exactly {4-bit exponent, 4-bit mantissa}.
  if (LEVEL_WIDTH != 8) begin : g_bad_level_width
    $error("band_envelope: LEVEL_WIDTH must be 8 with BAND_ENVELOPE_LOG_EN");
  end
`endif

  // Map an envelope value to the reported level.
  function automatic logic [LEVEL_WIDTH-1:0] to_level(input logic [ENV_W-1:0] e);
`ifdef BAND_ENVELOPE_LOG_EN
    to_level = LEVEL_WIDTH'(log_level(CALC_W'(e)));
`else
    to_level = e[ENV_W-1 -: LEVEL_WIDTH];
`endif
  endfunction

  state_e                 state_q, state_d;
  logic [ENV_W-1:0]       low_mag_q, low_mag_d;
  logic [ENV_W-1:0]       high_mag_q, high_mag_d;
  logic [LEVEL_WIDTH-1:0] low_level_q, low_level_d;
  logic [LEVEL_WIDTH-1:0] high_level_q, high_level_d;
  logic                   level_valid_q, level_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   low_upd, high_upd;
  logic [CALC_W-1:0]      low_abs, high_abs;
  logic [ENV_W-1:0]       low_env_q, low_env_d;
  logic [ENV_W-1:0]       high_env_q, high_env_d;

  assign low_abs  = abs_sat(CALC_W'(low_in), DATA_WIDTH);
  assign high_abs = abs_sat(CALC_W'(high_in), DATA_WIDTH);

  env_tracker #(
    .ENV_W       (ENV_W),
    .HOLD_SAMPLES(HOLD_SAMPLES),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_low_trk (
    .clk   (clk),
    .rst   (rst),
    .update(low_upd),
    .mag   (low_mag_q),
    .env_q (low_env_q),
    .env_d (low_env_d)
  );

  env_tracker #(
    .ENV_W       (ENV_W),
    .HOLD_SAMPLES(HOLD_SAMPLES),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_high_trk (
    .clk   (clk),
    .rst   (rst),
    .update(high_upd),
    .mag   (high_mag_q),
    .env_q (high_env_q),
    .env_d (high_env_d)
  );

  // Sequencer: capture on strobe, update low then high band, publish levels.
  always_comb begin
    state_d       = state_q;
    low_mag_d     = low_mag_q;
    high_mag_d    = high_mag_q;
    low_level_d   = low_level_q;
    high_level_d  = high_level_q;
    level_valid_d = 1'b0;
    overrun_d     = overrun_q;
    low_upd       = 1'b0;
    high_upd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          low_mag_d  = low_abs[ENV_W-1:0];
          high_mag_d = high_abs[ENV_W-1:0];
          state_d    = LOW;
        end
      end
      LOW: begin
        low_upd = 1'b1;
        state_d = HIGH;
        if (sample_valid) overrun_d = 1'b1;
      end
      HIGH: begin
        high_upd = 1'b1;
        // The low envelope settled last cycle; the high one settles now, so
        // take its next value to publish both levels together.
        low_level_d   = to_level(low_env_d);
        high_level_d  = to_level(high_env_d);
        level_valid_d = 1'b1;
        state_d       = IDLE;
        if (sample_valid) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      low_mag_q     <= '0;
      high_mag_q    <= '0;
      low_level_q   <= '0;
      high_level_q  <= '0;
      level_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      low_mag_q     <= low_mag_d;
      high_mag_q    <= high_mag_d;
      low_level_q   <= low_level_d;
      high_level_q  <= high_level_d;
      level_valid_q <= level_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign low_level   = low_level_q;
  assign high_level  = high_level_q;
  assign level_valid = level_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_band_envelope.sv
// Directed plus randomized bench for band_envelope with a short hold (4 samples).
// A behavioural model tracks both envelopes with plain integer arithmetic.
module tb_band_envelope;

  localparam int DW    = 16;
  localparam int LW    = 8;
  localparam int DS    = 6;
  localparam int HOLD  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_valid;
  logic signed [DW-1:0] low_in;
  logic signed [DW-1:0] high_in;
  logic [LW-1:0]        low_level;
  logic [LW-1:0]        high_level;
  logic                 level_valid;
  logic                 overrun;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = low band, 1 = high band.
  int m_env [2];
  int m_hold[2];

  band_envelope #(
    .DATA_WIDTH  (DW),
    .LEVEL_WIDTH (LW),
    .DECAY_SHIFT (DS),
    .HOLD_SAMPLES(HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .low_in      (low_in),
    .high_in     (high_in),
    .low_level   (low_level),
    .high_level  (high_level),
    .level_valid (level_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic int level_of(input int env);
`ifdef BAND_ENVELOPE_LOG_EN
    int e, t, m;
    e = 0;
    t = env;
    while (t > 0) begin
      e++;
      t = t / 2;
    end
    if (e == 0) m = 0;
    else if (e >= 5) m = (env >> (e - 5)) % 16;
    else m = (env << (5 - e)) % 16;
    return e * 16 + m;
`else
    return env / 128;
`endif
  endfunction

  task automatic model_band(input int b, input int x);
    int mg, dec;
    mg = mag_of(x);
    if (mg > m_env[b]) begin
      m_env[b]  = mg;
      m_hold[b] = HOLD;
    end else if (m_hold[b] > 0) begin
      m_hold[b]--;
    end else begin
      dec = m_env[b] / 64;
      if (dec < 1 && m_env[b] > 0) dec = 1;
      m_env[b] = m_env[b] - dec;
    end
  endtask

  task automatic model_reset();
    m_env  = '{0, 0};
    m_hold = '{0, 0};
  endtask

  // Pulse a strobe from the current negedge (cycle 0); returns at the negedge of cycle 3.
  task automatic run_sample(input int lo, input int hi);
    sample_valid = 1'b1;
    low_in       = DW'(lo);
    high_in      = DW'(hi);
    model_band(0, lo);
    model_band(1, hi);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("lv_c1", int'(level_valid), 0);
    @(negedge clk);
    chk("lv_c2", int'(level_valid), 0);
    @(negedge clk);
    chk("lv_c3", int'(level_valid), 1);
    chk("low_level", int'(low_level), level_of(m_env[0]));
    chk("high_level", int'(high_level), level_of(m_env[1]));
    chk("low_env", int'(dut.u_low_trk.env_q), m_env[0]);
    chk("high_env", int'(dut.u_high_trk.env_q), m_env[1]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int lv_cnt;
    int lo, hi, gap;
    int floor_exp[4];
    floor_exp = '{2, 1, 0, 0};
    rst          = 1'b1;
    sample_valid = 1'b0;
    low_in       = '0;
    high_in      = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_low_level", int'(low_level), 0);
    chk("rst_high_level", int'(high_level), 0);
    chk("rst_level_valid", int'(level_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Attack, hold, decay.
    run_sample(16000, 0);
    chk("attack_env", int'(dut.u_low_trk.env_q), 16000);
`ifndef BAND_ENVELOPE_LOG_EN
    chk("attack_level", int'(low_level), 125);
`else
    chk("log_16000", int'(low_level), 8'hEF);
`endif
    for (int i = 0; i < 4; i++) run_sample(0, 0);
    chk("hold_env", int'(dut.u_low_trk.env_q), 16000);
    run_sample(0, 0);
    chk("decay_env", int'(dut.u_low_trk.env_q), 15750);
`ifndef BAND_ENVELOPE_LOG_EN
    chk("decay_level", int'(low_level), 123);
`endif

    // Saturation on the high band.
    run_sample(0, -32768);
    chk("sat_neg_level", int'(high_level), level_of(32767));
    chk("sat_neg_env", int'(dut.u_high_trk.env_q), 32767);
    run_sample(0, 32767);
    chk("sat_pos_env", int'(dut.u_high_trk.env_q), 32767);

    // Decay floor from env = 3.
    do_reset(2);
    run_sample(3, 0);
    for (int i = 0; i < 4; i++) run_sample(0, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(0, 0);
      chk("floor_env", int'(dut.u_low_trk.env_q), floor_exp[i]);
    end

    // Log-mode boundary values (linear mode gives the model's levels too).
    do_reset(2);
    run_sample(1, 0);
    chk("small_level", int'(low_level), level_of(1));
    do_reset(2);
    run_sample(0, 0);
    chk("zero_level", int'(low_level), 0);

    // Overrun: strobes in cycles 0 and 2.
    do_reset(2);
    sample_valid = 1'b1;
    low_in       = DW'(5000);
    high_in      = DW'(-7000);
    model_band(0, 5000);
    model_band(1, -7000);
    lv_cnt = 0;
    @(negedge clk);
    sample_valid = 1'b0;
    lv_cnt += int'(level_valid);
    @(negedge clk);
    sample_valid = 1'b1;
    low_in       = DW'(30000);
    high_in      = DW'(30000);
    lv_cnt += int'(level_valid);
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ovr_lv_c3", int'(level_valid), 1);
    chk("ovr_low_level", int'(low_level), level_of(m_env[0]));
    chk("ovr_high_level", int'(high_level), level_of(m_env[1]));
    repeat (5) begin
      @(negedge clk);
      lv_cnt += int'(level_valid);
    end
    chk("ovr_extra_lv", lv_cnt, 0);
    chk("ovr_flag", int'(overrun), 1);

    // Strobes in cycles 0 and 3: both accepted, no overrun.
    do_reset(2);
    run_sample(2000, 3000);
    run_sample(9000, -100);
    chk("b2b_overrun", int'(overrun), 0);

    // Reset mid-operation: strobe one cycle before a 5-cycle reset.
    run_sample(20000, 20000);
    sample_valid = 1'b1;
    low_in       = DW'(12345);
    high_in      = DW'(-23456);
    @(negedge clk);
    sample_valid = 1'b0;
    lv_cnt = 0;
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      lv_cnt += int'(level_valid);
    end
    rst = 1'b0;
    model_reset();
    chk("mid_rst_low_level", int'(low_level), 0);
    chk("mid_rst_high_level", int'(high_level), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_env", int'(dut.u_low_trk.env_q), 0);
    repeat (4) begin
      @(negedge clk);
      lv_cnt += int'(level_valid);
    end
    chk("mid_rst_no_lv", lv_cnt, 0);

    // Randomized stream with random idle gaps.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       begin lo = 0; hi = 0; end
        1:       begin lo = int'($urandom_range(0, 200)) - 100; hi = int'($urandom_range(0, 65535)) - 32768; end
        default: begin lo = int'($urandom_range(0, 65535)) - 32768; hi = int'($urandom_range(0, 2000)) - 1000; end
      endcase
      run_sample(lo, hi);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end
    chk("final_overrun", int'(overrun), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/band_envelope.md
# band_envelope

Per-band envelope follower that sits directly downstream of the `fir_filter` stage. It consumes the low-pass (`data_out`) and high-pass (`high_pass_out`) samples on each `sample_valid` strobe, which arrives every ~1000 cycles at 48 kHz from a 48 MHz clock. For each band it computes a rectified peak-hold / exponential-decay envelope and emits one compact level per band with a single-cycle `level_valid` pulse for the display/LED logic.

## Interface
- `DATA_WIDTH`, 16: signed input sample width.
- `LEVEL_WIDTH`, 8: output level width; must be 8 when log mode is compiled in.
- `DECAY_SHIFT`, 6: decay step is `env >> DECAY_SHIFT` per sample.
- `HOLD_SAMPLES`, 2400: samples an attack peak is held before decay starts (50 ms).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe; both band inputs are valid in this cycle.
- `low_in`  in  DATA_WIDTH  signed low-band sample (from `data_out`).
- `high_in`  in  DATA_WIDTH  signed high-band sample (from `high_pass_out`).
- `low_level`  out  LEVEL_WIDTH  low-band level.
- `high_level`  out  LEVEL_WIDTH  high-band level.
- `level_valid`  out  1  one-cycle pulse when both levels update.
- `overrun`  out  1  sticky flag; a strobe arrived while busy.

## Operation
- FSM states: IDLE, LOW, HIGH.
  - IDLE to LOW on `sample_valid`: capture `low_in` and `high_in`.
  - LOW to HIGH: update the low envelope.
  - HIGH to IDLE: update the high envelope, register both levels, assert `level_valid`.
- Rectify: `mag = |x|` as unsigned DATA_WIDTH-1 bits. The most negative input saturates to the maximum (-32768 gives 32767).
- Envelope update per band (`env` is DATA_WIDTH-1 bits, `hold` is a counter):
  - Attack (`mag > env`): `env = mag`, `hold = HOLD_SAMPLES`.
  - Otherwise, if `hold != 0`: `hold` decrements and `env` is unchanged.
  - Otherwise, decay: `env = env - max(env >> DECAY_SHIFT, (env != 0))`. This guarantees `env` reaches 0 and never underflows.
  - `mag == env` counts as no-attack.
- Linear level is `env[DATA_WIDTH-2 -: LEVEL_WIDTH]`, the top bits of the magnitude.
- A `sample_valid` seen in LOW or HIGH is dropped and sets `overrun`. `overrun` is cleared only by `rst`.

## Timing
- Reset values: `low_level = 0`, `high_level = 0`, `level_valid = 0`, `overrun = 0`. Both `env` and both `hold` counters are 0; FSM is in IDLE.
- Latency: `sample_valid` high in cycle 0 gives `level_valid` high in cycle 3, with levels stable from cycle 3 until the next update.
- Minimum strobe spacing is 3 cycles. A strobe in cycle 3 (the `level_valid` cycle, FSM back in IDLE) is accepted.
- A strobe in cycles 1–2 is dropped and sets `overrun`.
- Reset mid-operation: the FSM returns to IDLE on the reset edge, no `level_valid` is produced for the in-flight sample, and envelopes are zeroed.
- `level_valid` is never asserted for two consecutive cycles.

## Configuration
- `BAND_ENVELOPE_LOG_EN` defined: the level is pseudo-logarithmic, `{e[3:0], m[3:0]}`.
  - `e` is MSB index of `env` + 1, or 0 when `env == 0`.
  - `m` is the 4 bits directly below the MSB, zero-padded on the right when fewer than 4 exist.
  - Elaboration fails if `LEVEL_WIDTH != 8`.
- Not defined: linear level as described above.
- Envelope arithmetic is identical in both modes; only the level mapping differs.

## Structure
- Package `band_envelope_pkg` holds:
  - the FSM state enum (IDLE, LOW, HIGH);
  - the `abs_sat` function;
  - the `log_level` function (MSB encode plus mantissa extract).
- Sub-module `env_tracker` contains one `env` register, one `hold` counter and the attack/hold/decay logic, with an `update` strobe input. It is instantiated twice, and the FSM drives `update` in LOW and HIGH respectively.

## Test plan
- Reset check: assert `rst` for 5 cycles mid-stream with a strobe issued one cycle before reset.
  - All outputs read 0 after reset.
  - No `level_valid` is produced for that strobe.
- Attack, hold and decay with `HOLD_SAMPLES=4` and linear mode:
  - `low_in = 16000` once gives `low_level = 125`.
  - The next 4 zero samples keep `low_level = 125`.
  - The 5th zero sample gives `env = 15750` and `low_level = 123`.
- Saturation: `high_in = -32768` gives `high_level = 255`; `high_in = 32767` also gives 255.
- Decay floor: with `env = 3` and `DECAY_SHIFT = 6`, zero samples after hold give `env` values 2, 1, 0, 0, with no wrap.
- Overrun: strobes in cycles 0 and 2 give exactly one `level_valid` (cycle 3) and `overrun = 1`. Strobes in cycles 0 and 3 give two `level_valid` pulses and `overrun = 0`.
- Log mode with `BAND_ENVELOPE_LOG_EN`: `low_in = 16000` gives `low_level = 0xEF`; `low_in = 1` gives 0x10; `low_in = 0` gives 0x00.
